// File: rtl/fifo_wr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and helpers for the FIFO write-side arbiter:
//   state_e         - two-state burst FSM encoding (IDLE / BURST)
//   beat_cnt_width  - width needed to count 0..burst_len beats
//   idx_width       - width of a requester index (at least 1 bit)
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  function automatic int beat_cnt_width(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundles the requester side and FIFO write side of the arbiter.
//   req / req_data  : per-requester request and packed write data
//   gnt             : per-requester beat accept
//   fifo_wr_en/data : FIFO write port
//   fifo_full/afull : FIFO status flags (write domain)
//   busy / owner    : burst ownership status
// Modports: master = arbiter side, slave = requesters/FIFO side.
// -----------------------------------------------------------------------------
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_REQ    = 4
) ();

  localparam int IW = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          fifo_full;
  logic                          fifo_afull;
  logic                          busy;
  logic [IW-1:0]                 owner;

  modport master (
    input  req, req_data, fifo_full, fifo_afull,
    output gnt, fifo_wr_en, fifo_wr_data, busy, owner
  );

  modport slave (
    output req, req_data, fifo_full, fifo_afull,
    input  gnt, fifo_wr_en, fifo_wr_data, busy, owner
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Round-robin priority search: returns the first requesting index found
// searching upward, with wrap, starting at last_owner+1.
//   req        : request vector
//   last_owner : index that owned most recently (lowest priority)
//   found      : at least one request present
//   index      : winning requester index
// -----------------------------------------------------------------------------
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_owner,
  output logic               found,
  output logic [IW-1:0]      index
);

  logic [IW-1:0] cand;

  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    // Offsets 1..NUM_REQ; offset NUM_REQ wraps back to last_owner itself,
    // so the previous owner wins only if nobody else is asking.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_owner) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter that lets NUM_REQ requesters take turns writing bursts
// of up to BURST_LEN beats into a FIFO write port.
//   clk   : FIFO write-side clock
//   rst_n : synchronous active-low reset
//   bus   : fifo_wr_arbiter_if.master (req, req_data, gnt, fifo_wr_en,
//           fifo_wr_data, fifo_full, fifo_afull, busy, owner)
// Build option: FIFO_WR_ARB_AFULL_THROTTLE_EN - when defined, no new burst is
// started while fifo_afull is high; otherwise fifo_afull is ignored.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4
) (
  input logic               clk,
  input logic               rst_n,
  fifo_wr_arbiter_if.master bus
);

  localparam int            IW        = idx_width(NUM_REQ);
  localparam int            CW        = beat_cnt_width(BURST_LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [IW-1:0] RST_LAST  = IW'(NUM_REQ - 1);

  state_e                state_q, state_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic [IW-1:0]         last_owner_q, last_owner_d;
  logic [CW-1:0]         beat_cnt_q, beat_cnt_d;

  logic                  pick_found;
  logic [IW-1:0]         pick_index;
  logic                  start_ok;
  logic                  in_burst;
  logic                  accept;
  logic [NUM_REQ-1:0]    gnt_c;
  logic [DATA_WIDTH-1:0] slice [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign slice[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_pick (
    .req        (bus.req),
    .last_owner (last_owner_q),
    .found      (pick_found),
    .index      (pick_index)
  );

`ifdef FIFO_WR_ARB_AFULL_THROTTLE_EN
  assign start_ok = pick_found && !bus.fifo_afull;
`else
  assign start_ok = pick_found;
`endif

  assign in_burst = (state_q == BURST);
  // rst_n gates the accept path so a reset landing mid-burst never lets a
  // beat through in the reset cycle itself.
  assign accept   = rst_n && in_burst && bus.req[owner_q] && !bus.fifo_full;

  always_comb begin
    gnt_c = '0;
    if (accept) begin
      gnt_c[owner_q] = 1'b1;
    end
  end

  assign bus.gnt          = gnt_c;
  assign bus.fifo_wr_en   = accept;
  assign bus.fifo_wr_data = in_burst ? slice[owner_q] : '0;
  assign bus.busy         = in_burst;
  assign bus.owner        = owner_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d    = BURST;
          owner_d    = pick_index;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        if (!bus.req[owner_q]) begin
          // Owner ran dry: give up the burst early.
          state_d      = IDLE;
          last_owner_d = owner_q;
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + CNT_ONE;
          if (beat_cnt_q + CNT_ONE == LAST_BEAT) begin
            state_d      = IDLE;
            last_owner_d = owner_q;
          end
        end
        // fifo_full with req held: stall indefinitely, count unchanged.
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= RST_LAST;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, BURST_LEN=4, DATA_WIDTH=4).
// A behavioural model of the arbitration rules is compared against the DUT on
// every cycle; literal expectations on the grant history pin the model.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int DW = 4;
  localparam int NR = 4;
  localparam int BL = 4;

  logic clk;
  logic rst_n;

  fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  fifo_wr_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .BURST_LEN  (BL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_valid = 0;
  bit m_busy  = 0;
  int m_owner = 0;
  int m_last  = NR - 1;
  int m_cnt   = 0;

  always @(posedge clk) begin : model_p
    bit nb; int no, nl, nc;
    nb = m_busy; no = m_owner; nl = m_last; nc = m_cnt;
    if (!rst_n) begin
      nb = 0; no = 0; nl = NR - 1; nc = 0;
    end else if (!m_busy) begin
      bit allow;
      allow = 1;
`ifdef FIFO_WR_ARB_AFULL_THROTTLE_EN
      if (bus.fifo_afull) allow = 0;
`endif
      if (allow) begin
        for (int k = 1; k <= NR; k++) begin
          int c;
          c = (m_last + k) % NR;
          if (!nb && bus.req[c]) begin
            nb = 1; no = c; nc = 0;
          end
        end
      end
    end else if (!bus.req[m_owner]) begin
      nb = 0; nl = m_owner;
    end else if (!bus.fifo_full) begin
      nc = m_cnt + 1;
      if (nc == BL) begin
        nb = 0; nl = m_owner;
      end
    end
    m_busy  <= nb;
    m_owner <= no;
    m_last  <= nl;
    m_cnt   <= nc;
    m_valid <= 1;
  end

  // ---------------- compare process ----------------
  int g_own[$];
  int g_dat[$];

  always @(negedge clk) begin : cmp_p
    if (m_valid) begin
      bit acc;
      int eg, ed;
      acc = rst_n && m_busy && bus.req[m_owner] && !bus.fifo_full;
      eg  = acc ? (1 << m_owner) : 0;
      ed  = m_busy ? int'((bus.req_data >> (DW * m_owner)) & 16'hF) : 0;
      chk("gnt", bus.gnt, eg);
      chk("fifo_wr_en", bus.fifo_wr_en, acc);
      chk("fifo_wr_data", bus.fifo_wr_data, ed);
      chk("busy", bus.busy, m_busy);
      chk("owner", bus.owner, m_owner);
      if (bus.fifo_wr_en) begin
        int o;
        o = -1;
        for (int i = 0; i < NR; i++) if (bus.gnt[i]) o = i;
        g_own.push_back(o);
        g_dat.push_back(int'(bus.fifo_wr_data));
        $display("beat owner=%0d data=%0d t=%0t", o, bus.fifo_wr_data, $time);
      end
    end
  end

  // ---------------- driver ----------------
  logic [NR-1:0] last_gnt;
  logic          last_wren;

  task automatic step(input logic [NR-1:0] r, input bit full, input bit af, input bit rn);
    bus.req        = r;
    bus.fifo_full  = full;
    bus.fifo_afull = af;
    rst_n          = rn;
    @(negedge clk);
    last_gnt  = bus.gnt;
    last_wren = bus.fifo_wr_en;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step('0, 0, 0, 0);
    step('0, 0, 0, 1);
    g_own.delete();
    g_dat.delete();
  endtask

  initial begin
    bus.req_data   = {4'd8, 4'd7, 4'd6, 4'd5};
    bus.req        = '0;
    bus.fifo_full  = 0;
    bus.fifo_afull = 0;
    rst_n          = 0;

    // Reset state
    step('0, 0, 0, 0);
    step('0, 0, 0, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_owner", bus.owner, 0);
    step('0, 0, 0, 1);

    // All requesting: owners 0,1,2,3,0 with 4 beats each, one idle between
    g_own.delete(); g_dat.delete();
    repeat (25) step(4'b1111, 0, 0, 1);
    chk("rr_beats", g_own.size(), 20);
    for (int i = 0; i < 20 && i < g_own.size(); i++) begin
      chk("rr_owner", g_own[i], (i / 4) % 4);
      chk("rr_data", g_dat[i], ((i / 4) % 4) + 5);
    end
    chk("rr_idle_after", bus.busy, 0);
    step('0, 0, 0, 1);

    // Early exit: requester 2 present for two beats only
    do_reset();
    repeat (3) step(4'b0100, 0, 0, 1);
    step('0, 0, 0, 1);
    chk("early_busy", bus.busy, 0);
    chk("early_beats", g_own.size(), 2);
    if (g_own.size() == 2) begin
      chk("early_own0", g_own[0], 2);
      chk("early_dat1", g_dat[1], 7);
    end
    step(4'b1111, 0, 0, 1);
    chk("early_next_owner", bus.owner, 3);
    step('0, 0, 0, 1);

    // fifo_full stall for 3 cycles mid-burst
    do_reset();
    repeat (3) step(4'b0001, 0, 0, 1);
    repeat (3) begin
      step(4'b0001, 1, 0, 1);
      chk("stall_wren", last_wren, 0);
    end
    chk("stall_beats_before", g_own.size(), 2);
    step(4'b0001, 0, 0, 1);
    chk("stall_busy_mid", bus.busy, 1);
    step(4'b0001, 0, 0, 1);
    chk("stall_beats", g_own.size(), 4);
    chk("stall_done", bus.busy, 0);
    step('0, 0, 0, 1);

    // Reset during beat 2 of owner 1
    do_reset();
    step(4'b0010, 0, 0, 1);
    step(4'b0010, 0, 0, 1);
    step(4'b0010, 0, 0, 0);
    chk("rstmid_gnt", last_gnt, 0);
    chk("rstmid_wren", last_wren, 0);
    repeat (5) step(4'b0011, 0, 0, 1);
    chk("rstmid_beats", g_own.size(), 5);
    if (g_own.size() >= 2) begin
      chk("rstmid_first", g_own[0], 1);
      chk("rstmid_after", g_own[1], 0);
    end
    step('0, 0, 0, 1);
    step('0, 0, 0, 1);

    // Almost-full in IDLE
    do_reset();
    step(4'b0001, 0, 1, 1);
`ifdef FIFO_WR_ARB_AFULL_THROTTLE_EN
    chk("afull_busy1", bus.busy, 0);
    step(4'b0001, 0, 1, 1);
    chk("afull_busy2", bus.busy, 0);
    step(4'b0001, 0, 0, 1);
    chk("afull_busy3", bus.busy, 1);
`else
    chk("afull_busy1", bus.busy, 1);
    step(4'b0001, 0, 1, 1);
    chk("afull_beats", g_own.size(), 1);
`endif
    step('0, 0, 0, 1);
    step('0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
